// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the combinational instruction
// memory and buffers {pc, instr} pairs in a small queue toward decode.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FQ_DEPTH);

  typedef enum logic {RUN, FAULT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       fault_pc_q, fault_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  fq_entry_t         fq_mem [FQ_DEPTH];
  logic              dequeue;
  logic              push;

  // The memory address comes straight from the PC flop, so imem timing never
  // depends on redirect or handshake inputs.
  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0) && (state_q == RUN);
  assign dequeue   = out_valid && out_ready;
  assign out_pc    = fq_mem[rd_ptr_q].pc;
  assign out_instr = fq_mem[rd_ptr_q].instr;
  assign fault     = (state_q == FAULT);
  assign fault_pc  = fault_pc_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can leave it unassigned (no latches).
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push       = 1'b0;

    if (redirect_valid) begin
      // Redirect wins over everything: flush the queue, then retarget or fault.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        state_d = RUN;
      end else begin
        state_d    = FAULT;
        fault_pc_d = redirect_pc;
      end
    end else if (state_q == RUN) begin
      // A full queue may still accept a word when the head leaves on the same edge.
      push = fetch_en && ((count_q < CNT_FULL) || dequeue);
      if (dequeue) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        pc_d     = pc_q + 32'd4;
      end
      case ({push, dequeue})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the queue storage is reset because the head is visible on out_pc/out_instr,
      // which must read zero out of reset; it is only FQ_DEPTH entries.
      for (int i = 0; i < FQ_DEPTH; i++) fq_mem[i] <= '0;
    end else if (push) begin
      fq_mem[wr_ptr_q] <= '{pc: pc_q, instr: imem_instr};
    end
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequences the combinational instruction memory (instr_mem) for the single-issue RISC-V core. Owns the program counter, drives the memory address each cycle and captures the returned word with its PC into a small fetch queue. Presents fetched instructions to decode over a valid/ready handshake. Handles branch/jump redirects (flush plus new PC), a global fetch enable, and misaligned-target faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FQ_DEPTH, 2, fetch queue entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  1 = fetch allowed; 0 = PC holds, no pushes
imem_addr  out  32  address to instr_mem addr_from_pc (= PC register)
imem_instr  in  32  instr_mem instruction output, valid same cycle as imem_addr
redirect_valid  in  1  1-cycle pulse: branch/jump taken
redirect_pc  in  32  redirect target
out_valid  out  1  queue head holds a valid instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  head instruction
out_pc  out  32  PC of head instruction
fault  out  1  misaligned redirect target latched
fault_pc  out  32  offending target address

Behaviour:
- Reset (async, immediate, any state): PC=RESET_PC, queue count=0, rd/wr pointers=0, state=RUN, fault=0, fault_pc=0; outputs: imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- imem_addr is PC register directly (no combinational path from inputs).
- States: RUN, FAULT.
- dequeue = out_valid & out_ready. Queue head visible combinationally from storage; out_valid = (count!=0) & state==RUN.
- push (RUN, no redirect) = fetch_en & (count<FQ_DEPTH | dequeue). On push: entry={PC, imem_instr}, wr_ptr++, PC<=PC+4. Dequeue and push in same cycle: count unchanged; at full, allowed (slot freed same edge).
- Latency: word at address A available at out_* the cycle after PC=A; steady state 1 instruction/cycle with out_ready=1.
- PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 = 0, no flag.
- Redirect (highest priority, any state): queue flushed (count=0, pointers=0), no push, dequeue ignored that cycle. If redirect_pc[1:0]==0: PC<=redirect_pc, state=RUN, fault=0. Else: state=FAULT, fault=1, fault_pc=redirect_pc, PC unchanged.
- FAULT: no pushes, out_valid=0, fault held at 1; exits only via aligned redirect (next cycle fault=0, fetch resumes) or reset.
- fetch_en=0 in RUN: PC holds, queue still drains via dequeue.
- redirect_valid and fetch_en=0 together: PC updated, queue flushed, no fetch until fetch_en=1.
- Queue pointers wrap modulo FQ_DEPTH; count range 0..FQ_DEPTH.

Test Plan:
- Reset/steady run: rst_n low then high, fetch_en=1, out_ready=1, memory words 0xDEACAEEF/0x12345678/0xAABBCCDD at 0/4/8 -> imem_addr 0,4,8 on successive cycles; out (pc,instr) = (0,DEACAEEF),(4,12345678),(8,AABBCCDD) one cycle later each, no bubbles.
- Backpressure: out_ready=0 from cycle 0 -> count reaches 2, PC stalls at 8, out_pc stays 0; out_ready=1 -> drains 0,4 then continues from 8 with no lost/duplicate PC.
- Redirect with full queue: count=2, redirect_valid=1, redirect_pc=0x40 -> next cycle out_valid=0, imem_addr=0x40; following cycle out_pc=0x40.
- Misaligned redirect: redirect_pc=0x42 -> fault=1, fault_pc=0x42, out_valid=0, imem_addr frozen for 5 cycles; then redirect_pc=0x80 -> fault=0, out_pc=0x80 next cycle.
- Wrap and enable: redirect to 0xFFFF_FFFC, fetch_en=1 -> out_pc 0xFFFF_FFFC then 0x0000_0000; fetch_en=0 mid-run -> PC holds, queue drains to out_valid=0.
- Async reset mid-operation: rst_n low between clock edges with count=2 -> out_valid=0, imem_addr=RESET_PC immediately without clock edge.
